dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 29 ++
 rtl/dmem_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if -- request/response bundle between the EX/MEM stage and the
// data-memory controller.
//   MemRead_i / MemWrite_i : access request (both high = illegal request)
//   Addr_i                 : byte address
//   WData_i                : store data
//   RData_o                : load data presented to MEM/WB
//   stall_o                : pipeline freeze request
//   ack_o / err_o          : one-cycle completion / error pulses
// Signal names keep the controller's point of view (_i into, _o out of it).
interface dmem_ctrl_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WData_i;
    logic [31:0] RData_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    modport slave (
        input  MemRead_i, MemWrite_i, Addr_i, WData_i,
        output RData_o, stall_o, ack_o, err_o
    );

    modport master (
        output MemRead_i, MemWrite_i, Addr_i, WData_i,
        input  RData_o, stall_o, ack_o, err_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory controller with internal word storage.
// An access is latched in IDLE, spends LATENCY cycles in BUSY, commits on the
// last BUSY edge and retires in DONE with a one-cycle ack_o (and err_o for
// illegal, misaligned or out-of-range accesses).
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset (clears state, outputs and storage)
//   bus    : dmem_ctrl_if.slave request/response bundle
module dmem_ctrl #(
    parameter int unsigned LATENCY = 3,   // BUSY cycles per access, 1..15
    parameter int unsigned DEPTH   = 64   // 32-bit words of storage
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dmem_ctrl_if.slave   bus
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem_q [DEPTH];

    logic            req_any;
    logic            latch;
    logic            commit;
    logic            err_in;

    // Any raised request line starts an access; the illegal case (both high)
    // runs through the normal timing and is flagged as an error.
    assign req_any = bus.MemRead_i | bus.MemWrite_i;

    assign err_in = (bus.MemRead_i & bus.MemWrite_i)
                  | (bus.Addr_i[1:0] != 2'b00)
                  | ({1'b0, bus.Addr_i} >= LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch       = 1'b0;
        commit      = 1'b0;
        bus.stall_o = 1'b0;
        bus.ack_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    latch       = 1'b1;
                    bus.stall_o = 1'b1;
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                bus.stall_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Request lines still carry the retiring instruction here.
                bus.ack_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.err_o   = bus.ack_o & err_q;
    assign bus.RData_o = rdata_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                wr_q    <= bus.MemWrite_i & ~bus.MemRead_i;
                err_q   <= err_in;
                idx_q   <= bus.Addr_i[AW+1:2];
                wdata_q <= bus.WData_i;
            end
            if (commit) begin
                if (err_q) begin
                    rdata_q <= '0;
                end else if (!wr_q) begin
                    rdata_q <= mem_q[idx_q];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && wr_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule
